gather_8: RTL and testbench



---
 rtl/gather_8_pkg.sv | 10 +
 rtl/gather_8.sv | 93 +++++++++
 tb/tb_gather_8.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/gather_8_pkg.sv
// Shared tq types: coefficient width, row length, signed coefficient type.
// Imported by the gather and permutation stages of the tq row path.
package gather_8_pkg;

    localparam int TQ_COEF_W = 28;
    localparam int TQ_ROW8   = 8;

    typedef logic signed [TQ_COEF_W-1:0] tq_coef_t;

endpackage

// File: rtl/gather_8.sv
// gather_8: collects 8 serial signed samples into a parallel row.
// Ports: clk, rst (sync, high); i_valid/i_start/i_enable/i_inverse/i_data
// in; o_valid, o_enable, o_inverse, o_0..o_7 (row), o_drop out.
module gather_8
    import gather_8_pkg::*;
#(
    parameter int WIDTH = TQ_COEF_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    input  logic                    i_start,
    input  logic                    i_enable,
    input  logic                    i_inverse,
    input  logic signed [WIDTH-1:0] i_data,
    output logic                    o_valid,
    output logic                    o_enable,
    output logic                    o_inverse,
    output logic signed [WIDTH-1:0] o_0,
    output logic signed [WIDTH-1:0] o_1,
    output logic signed [WIDTH-1:0] o_2,
    output logic signed [WIDTH-1:0] o_3,
    output logic signed [WIDTH-1:0] o_4,
    output logic signed [WIDTH-1:0] o_5,
    output logic signed [WIDTH-1:0] o_6,
    output logic signed [WIDTH-1:0] o_7,
    output logic                    o_drop
);

    // idx == 0 is the row-start state; 1..7 means a row is filling.
    logic [2:0]              idx;
    logic signed [WIDTH-1:0] s_bank [TQ_ROW8];
    logic                    s_enable;
    logic                    s_inverse;
    logic signed [WIDTH-1:0] o_bank [TQ_ROW8];

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            s_enable  <= 1'b0;
            s_inverse <= 1'b0;
            o_valid   <= 1'b0;
            o_drop    <= 1'b0;
            o_enable  <= 1'b0;
            o_inverse <= 1'b0;
            for (int k = 0; k < TQ_ROW8; k++) begin
                s_bank[k] <= '0;
                o_bank[k] <= '0;
            end
        end else begin
            o_valid <= 1'b0;
            o_drop  <= 1'b0;
            if (i_valid) begin
                if (i_start) begin
                    // Restart: any partial row is abandoned.
                    s_bank[0] <= i_data;
                    s_enable  <= i_enable;
                    s_inverse <= i_inverse;
                    idx       <= 3'd1;
                    o_drop    <= (idx != 3'd0);
                end else begin
                    s_bank[idx] <= i_data;
                    if (idx == 3'd0) begin
                        s_enable  <= i_enable;
                        s_inverse <= i_inverse;
                    end
                    idx <= idx + 3'd1;
                    if (idx == 3'd7) begin
                        // Last slot bypasses the shadow bank so the
                        // next row may start on the following cycle.
                        for (int k = 0; k < TQ_ROW8 - 1; k++) begin
                            o_bank[k] <= s_bank[k];
                        end
                        o_bank[7] <= i_data;
                        o_enable  <= s_enable;
                        o_inverse <= s_inverse;
                        o_valid   <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_0 = o_bank[0];
    assign o_1 = o_bank[1];
    assign o_2 = o_bank[2];
    assign o_3 = o_bank[3];
    assign o_4 = o_bank[4];
    assign o_5 = o_bank[5];
    assign o_6 = o_bank[6];
    assign o_7 = o_bank[7];

endmodule

// File: tb/tb_gather_8.sv
// Bench for gather_8: queue-based row model, per-cycle compare,
// directed scenarios with literal expectations, then random traffic.
module tb_gather_8;

    localparam int W = 28;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_valid = 1'b0;
    logic         i_start = 1'b0;
    logic         i_enable = 1'b0;
    logic         i_inverse = 1'b0;
    logic [W-1:0] i_data = '0;
    logic         o_valid, o_enable, o_inverse, o_drop;
    logic [W-1:0] o_0, o_1, o_2, o_3, o_4, o_5, o_6, o_7;

    int total = 0;
    int bad = 0;

    gather_8 #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_start(i_start),
        .i_enable(i_enable), .i_inverse(i_inverse),
        .i_data(i_data),
        .o_valid(o_valid), .o_enable(o_enable),
        .o_inverse(o_inverse),
        .o_0(o_0), .o_1(o_1), .o_2(o_2), .o_3(o_3),
        .o_4(o_4), .o_5(o_5), .o_6(o_6), .o_7(o_7),
        .o_drop(o_drop)
    );

    always #5 clk = ~clk;

    // Behavioural model: the row is a queue of accepted samples.
    logic [W-1:0] row [$];
    logic         m_en, m_inv;
    logic [W-1:0] exp_o [8];
    logic         exp_en, exp_inv, exp_valid, exp_drop;
    bit           armed = 0;

    always @(posedge clk) begin
        if (rst) begin
            row.delete();
            m_en = 0; m_inv = 0;
            for (int k = 0; k < 8; k++) exp_o[k] = '0;
            exp_en = 0; exp_inv = 0;
            exp_valid = 0; exp_drop = 0;
            armed = 1;
        end else begin
            exp_valid = 0;
            exp_drop = 0;
            if (i_valid) begin
                if (i_start) begin
                    exp_drop = (row.size() != 0);
                    row.delete();
                end
                if (row.size() == 0) begin
                    m_en = i_enable;
                    m_inv = i_inverse;
                end
                row.push_back(i_data);
                if (row.size() == 8) begin
                    for (int k = 0; k < 8; k++) exp_o[k] = row[k];
                    exp_en = m_en;
                    exp_inv = m_inv;
                    exp_valid = 1;
                    row.delete();
                end
            end
        end
    end

    task automatic check(input string name,
                         input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (armed) begin
            check("valid", W'(o_valid), W'(exp_valid));
            check("drop", W'(o_drop), W'(exp_drop));
            check("enable", W'(o_enable), W'(exp_en));
            check("inverse", W'(o_inverse), W'(exp_inv));
            check("o_0", o_0, exp_o[0]);
            check("o_1", o_1, exp_o[1]);
            check("o_2", o_2, exp_o[2]);
            check("o_3", o_3, exp_o[3]);
            check("o_4", o_4, exp_o[4]);
            check("o_5", o_5, exp_o[5]);
            check("o_6", o_6, exp_o[6]);
            check("o_7", o_7, exp_o[7]);
        end
    end

    task automatic drive(input logic v, input logic s,
                         input logic en, input logic inv,
                         input logic [W-1:0] d);
        @(negedge clk);
        rst = 1'b0;
        i_valid = v; i_start = s;
        i_enable = en; i_inverse = inv;
        i_data = d;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            drive(0, 0, 0, 0, W'($urandom));
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1; i_valid = 0; i_start = 0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    // Send values base..base+n-1; start on the first, inv toggle option.
    task automatic send(input int base, input int n, input bit st,
                        input logic en, input logic inv);
        for (int k = 0; k < n; k++)
            drive(1, st && k == 0, en, inv, W'(base + k));
    endtask

    int vcyc;
    int gap;

    initial begin
        do_reset(2);
        check("rst_valid", W'(o_valid), '0);
        check("rst_o0", o_0, '0);
        check("rst_o7", o_7, '0);

        // Row 1..8.
        send(1, 8, 1, 1, 0);
        idle(1);
        check("r1_valid", W'(o_valid), W'(1));
        check("r1_o0", o_0, W'(1));
        check("r1_o7", o_7, W'(8));
        check("r1_en", W'(o_enable), W'(1));
        check("r1_inv", W'(o_inverse), '0);
        idle(1);
        check("r1_hold_v", W'(o_valid), '0);
        check("r1_hold_o3", o_3, W'(4));

        // Back-to-back rows -1..-8 and 100..107, count spacing.
        for (int k = 0; k < 8; k++)
            drive(1, k == 0, 1, 0, W'(-(k + 1)));
        for (int k = 0; k < 8; k++) begin
            drive(1, k == 0, 1, 1, W'(100 + k));
            if (k == 0) begin
                vcyc = 0;
                check("bb1_o0", o_0, 28'hFFFFFFF);
                check("bb1_o7", o_7, 28'hFFFFFF8);
            end
            if (o_valid) vcyc = 0; else vcyc++;
        end
        idle(1);
        check("bb2_valid", W'(o_valid), W'(1));
        check("bb2_gap", W'(vcyc), W'(7));
        check("bb2_o0", o_0, W'(100));
        check("bb2_o7", o_7, W'(107));
        check("bb2_inv", W'(o_inverse), W'(1));

        // Gaps after samples 2 and 5, inverse toggling mid-row.
        for (int k = 0; k < 8; k++) begin
            drive(1, k == 0, 0, k[0], W'(20 + k));
            if (k == 1 || k == 4) idle(3);
        end
        idle(1);
        check("gap_valid", W'(o_valid), W'(1));
        check("gap_o4", o_4, W'(24));
        check("gap_inv", W'(o_inverse), '0);

        // 5 samples then restart with 50..57.
        send(1, 5, 1, 1, 0);
        send(50, 1, 1, 1, 1);
        drive(1, 0, 0, 0, W'(51));
        check("rs_drop", W'(o_drop), W'(1));
        check("rs_nov", W'(o_valid), '0);
        send(52, 6, 0, 0, 0);
        idle(1);
        check("rs_valid", W'(o_valid), W'(1));
        check("rs_o0", o_0, W'(50));
        check("rs_o7", o_7, W'(57));
        check("rs_inv", W'(o_inverse), W'(1));

        // Reset mid-row, then 9..16.
        send(1, 4, 1, 1, 1);
        do_reset(1);
        check("mr_o0", o_0, '0);
        check("mr_drop", W'(o_drop), '0);
        send(9, 8, 1, 1, 0);
        idle(1);
        check("mr_o0b", o_0, W'(9));
        check("mr_o7b", o_7, W'(16));

        // Start on would-be slot 7.
        send(30, 7, 1, 0, 0);
        send(99, 1, 1, 1, 0);
        drive(1, 0, 0, 0, W'(1));
        check("s7_drop", W'(o_drop), W'(1));
        check("s7_nov", W'(o_valid), '0);
        send(2, 6, 0, 0, 0);
        idle(1);
        check("s7_o0", o_0, W'(99));
        check("s7_en", W'(o_enable), W'(1));

        // Random traffic.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset($urandom_range(1, 2));
            end else begin
                gap = $urandom_range(0, 99);
                drive(gap < 75, $urandom_range(0, 99) < 8,
                      1'($urandom), 1'($urandom), W'($urandom));
            end
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
